// File: rtl/irq_loopback_pkg.sv
// Shared types and constants for the IRQ loopback block: FSM state
// encoding, the LFSR feedback polynomial and its default seed.
package irq_loopback_pkg;

    // Return-scheduler states: IDLE looks for a queued word, WAIT burns the
    // random delay before the word is handed back to the CPU.
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

    // Galois feedback mask for x^16 + x^14 + x^13 + x^11 + 1 (right shift).
    localparam logic [15:0] LFSR_TAPS    = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

    // One step of the right-shifting Galois LFSR.
    function automatic logic [15:0] lfsr_step(input logic [15:0] state);
        logic [15:0] next;
        next = {1'b0, state[15:1]};
        if (state[0]) begin
            next = next ^ LFSR_TAPS;
        end else begin
            next = next;
        end
        return next;
    endfunction

endpackage

// File: rtl/irq_fifo.sv
// Capture FIFO for the IRQ loopback. A push while full is accepted only
// when a pop happens in the same cycle; otherwise the caller sees full_o
// and must treat the word as dropped. Pops on an empty FIFO are ignored.
module irq_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE  = {{(PTR_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full_o  = (count_q == CNT_FULL);
    assign empty_o = (count_q == CNT_ZERO);
    assign head_o  = mem_q[rd_ptr_q];

    // Decide which requests take effect and compute next pointers/occupancy.
    always_comb begin
        pop_ok_s  = pop_i && !empty_o;
        push_ok_s = push_i && (!full_o || pop_ok_s);
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (push_ok_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_ok_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers; reset empties the FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= CNT_ZERO;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are only meaningful below the occupancy count.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/irq_loopback.sv
// IRQ loopback: every change on the CPU's outgoing IRQ word is captured,
// queued, and handed back on o_irq after a pseudo-random extra delay.
module irq_loopback
    import irq_loopback_pkg::*;
#(
    parameter int          FIFO_DEPTH = 8,
    parameter int          DELAY_W    = 4,
    parameter logic [15:0] SEED       = DEFAULT_SEED
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] i_irq,
    output logic [31:0] o_irq,
    output logic [31:0] o_count,
    output logic        o_overflow,
    output logic        o_dup_err
);

    localparam logic [DELAY_W-1:0] D_ZERO = {DELAY_W{1'b0}};
    localparam logic [DELAY_W-1:0] D_ONE  = {{(DELAY_W-1){1'b0}}, 1'b1};

    state_e              state_q, state_d;
    logic [DELAY_W-1:0]  cnt_q, cnt_d;
    logic [15:0]         lfsr_q, lfsr_d;
    logic [31:0]         i_irq_q;
    logic [31:0]         o_irq_q, o_irq_d;
    logic [31:0]         count_q, count_d;
    logic                overflow_q, overflow_d;
    logic                dup_err_q, dup_err_d;

    logic                capture_s;
    logic                emit_s;
    logic                fifo_full_s;
    logic                fifo_empty_s;
    logic [31:0]         fifo_head_s;
    logic [DELAY_W-1:0]  delay_s;

    assign capture_s = (i_irq != i_irq_q);
    assign delay_s   = lfsr_q[DELAY_W-1:0];

    irq_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (capture_s),
        .pop_i   (emit_s),
        .data_i  (i_irq),
        .head_o  (fifo_head_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s)
    );

    // Scheduler: pick a delay for the head word and decide when to emit it.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        emit_s  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty_s) begin
                    if (delay_s == D_ZERO) begin
                        emit_s = 1'b1;
                    end else begin
                        cnt_d   = delay_s - D_ONE;
                        state_d = ST_WAIT;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_q == D_ZERO) begin
                    emit_s  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - D_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = D_ZERO;
            end
        endcase
    end

    // Output datapath: emit updates o_irq/count/LFSR; error flags are sticky.
    always_comb begin
        o_irq_d    = o_irq_q;
        count_d    = count_q;
        lfsr_d     = lfsr_q;
        overflow_d = overflow_q;
        dup_err_d  = dup_err_q;
        if (emit_s) begin
            o_irq_d = fifo_head_s;
            count_d = count_q + 32'd1;
            lfsr_d  = lfsr_step(lfsr_q);
            if (fifo_head_s == o_irq_q) begin
                dup_err_d = 1'b1;
            end else begin
                dup_err_d = dup_err_q;
            end
        end else begin
            o_irq_d = o_irq_q;
        end
        if (capture_s && fifo_full_s && !emit_s) begin
            overflow_d = 1'b1;
        end else begin
            overflow_d = overflow_q;
        end
    end

    // Scheduler state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= D_ZERO;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Input sampler, LFSR and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_irq_q    <= 32'd0;
            o_irq_q    <= 32'd0;
            count_q    <= 32'd0;
            overflow_q <= 1'b0;
            dup_err_q  <= 1'b0;
            lfsr_q     <= SEED;
        end else begin
            i_irq_q    <= i_irq;
            o_irq_q    <= o_irq_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            dup_err_q  <= dup_err_d;
            lfsr_q     <= lfsr_d;
        end
    end

    assign o_irq      = o_irq_q;
    assign o_count    = count_q;
    assign o_overflow = overflow_q;
    assign o_dup_err  = dup_err_q;

endmodule

// File: tb/tb_irq_loopback.sv
// Bench for irq_loopback. Three instances:
//   [0] SEED 16'h0010, depth 8  : zero-delay latency, reset behaviour
//   [1] SEED 16'hACEF, depth 4  : overflow (first delay 15) and duplicate
//   [2] SEED 16'hACE1, depth 32 : one-cycle delay, random stream
// A per-instance scoreboard queue holds the words expected back, in order.
module tb_irq_loopback;

    logic        clk;
    logic        rst_n;
    logic [31:0] irq_in  [3];
    logic [31:0] irq_out [3];
    logic [31:0] cnt     [3];
    logic        ovf     [3];
    logic        dup     [3];

    logic [31:0] sb   [3][$];
    logic [31:0] prev [3];

    int n_checks = 0;
    int n_errors = 0;

    irq_loopback #(.FIFO_DEPTH(8), .DELAY_W(4), .SEED(16'h0010)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .i_irq(irq_in[0]), .o_irq(irq_out[0]),
        .o_count(cnt[0]), .o_overflow(ovf[0]), .o_dup_err(dup[0]));

    irq_loopback #(.FIFO_DEPTH(4), .DELAY_W(4), .SEED(16'hACEF)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .i_irq(irq_in[1]), .o_irq(irq_out[1]),
        .o_count(cnt[1]), .o_overflow(ovf[1]), .o_dup_err(dup[1]));

    irq_loopback #(.FIFO_DEPTH(32), .DELAY_W(4), .SEED(16'hACE1)) u_dut_c (
        .clk(clk), .rst_n(rst_n), .i_irq(irq_in[2]), .o_irq(irq_out[2]),
        .o_count(cnt[2]), .o_overflow(ovf[2]), .o_dup_err(dup[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Move to just after the next rising edge (start of a new cycle).
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every count increment must pop the next expected word.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (!rst_n) begin
                prev[i] = 32'd0;
            end else if (cnt[i] != prev[i]) begin
                check($sformatf("emit_step_%0d", i), cnt[i], prev[i] + 32'd1);
                check($sformatf("emit_expected_%0d", i), {31'd0, sb[i].size() != 0}, 32'd1);
                if (sb[i].size() != 0) begin
                    check($sformatf("order_%0d", i), irq_out[i], sb[i].pop_front());
                end
                prev[i] = cnt[i];
            end
        end
    end

    initial begin
        int          n;
        int          g1;
        int          g2;
        logic [31:0] v;

        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) irq_in[i] = 32'd0;

        // Reset state of every instance
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rst_irq_%0d", i), irq_out[i], 32'd0);
            check($sformatf("rst_count_%0d", i), cnt[i], 32'd0);
            check($sformatf("rst_ovf_%0d", i), {31'd0, ovf[i]}, 32'd0);
            check($sformatf("rst_dup_%0d", i), {31'd0, dup[i]}, 32'd0);
        end
        step();
        step();
        rst_n = 1'b1;

        // Zero extra delay: word visible two cycles after the change
        step();
        irq_in[0] = 32'h1234_5678;
        sb[0].push_back(32'h1234_5678);
        @(negedge clk); check("a_lat_c0", irq_out[0], 32'd0);
        step(); @(negedge clk); check("a_lat_c1", irq_out[0], 32'd0);
        step(); @(negedge clk); check("a_lat_c2", irq_out[0], 32'h1234_5678);
        check("a_count1", cnt[0], 32'd1);

        // One extra cycle (seed ACE1 -> d=1): visible three cycles later
        step();
        irq_in[2] = 32'hCAFE_0001;
        sb[2].push_back(32'hCAFE_0001);
        @(negedge clk); check("c_lat_c0", irq_out[2], 32'd0);
        step(); @(negedge clk); check("c_lat_c1", irq_out[2], 32'd0);
        step(); @(negedge clk); check("c_lat_c2", irq_out[2], 32'd0);
        step(); @(negedge clk); check("c_lat_c3", irq_out[2], 32'hCAFE_0001);
        check("c_count1", cnt[2], 32'd1);

        // LFSR advanced to 16'hE270 (d=0): next word back after two cycles
        step();
        irq_in[2] = 32'hCAFE_0002;
        sb[2].push_back(32'hCAFE_0002);
        step(); @(negedge clk); check("c_lat2_c1", irq_out[2], 32'hCAFE_0001);
        step(); @(negedge clk); check("c_lat2_c2", irq_out[2], 32'hCAFE_0002);

        // Overflow: six back-to-back changes into a depth-4 FIFO, delay 15
        for (int k = 1; k <= 6; k++) begin
            step();
            irq_in[1] = 32'(k);
            if (k <= 4) sb[1].push_back(32'(k));
        end
        n = 0;
        while (cnt[1] != 32'd4 && n < 300) begin step(); n++; end
        repeat (20) step();
        @(negedge clk);
        check("b_drain_count", cnt[1], 32'd4);
        check("b_last_word", irq_out[1], 32'd4);
        check("b_overflow", {31'd0, ovf[1]}, 32'd1);
        check("b_no_dup_yet", {31'd0, dup[1]}, 32'd0);

        // Duplicate: dropped words leave i_irq_q=6; next word equals o_irq (4)
        step();
        irq_in[1] = 32'd4;
        sb[1].push_back(32'd4);
        n = 0;
        while (cnt[1] != 32'd5 && n < 100) begin step(); n++; end
        @(negedge clk);
        check("b_dup_count", cnt[1], 32'd5);
        check("b_dup_err", {31'd0, dup[1]}, 32'd1);
        check("b_dup_word", irq_out[1], 32'd4);
        check("a_no_ovf", {31'd0, ovf[0]}, 32'd0);
        check("a_no_dup", {31'd0, dup[0]}, 32'd0);

        // Random CPU-style stream of 1000 changes into the depth-32 instance
        for (int i = 0; i < 1000; i++) begin
            step();
            v = $urandom;
            if (v == irq_in[2]) v = ~v;
            irq_in[2] = v;
            sb[2].push_back(v);
            g1 = $urandom_range(15, 0);
            g2 = $urandom_range(15, 0);
            if (g2 > g1) g1 = g2;
            repeat (g1) step();
        end
        n = 0;
        while (sb[2].size() != 0 && n < 2000) begin step(); n++; end
        repeat (3) step();
        @(negedge clk);
        check("c_pending", 32'(sb[2].size()), 32'd0);
        check("c_count", cnt[2], 32'd1002);
        check("c_no_ovf", {31'd0, ovf[2]}, 32'd0);
        check("c_no_dup", {31'd0, dup[2]}, 32'd0);

        // Reset while WAITing with three words queued (d=8 for instance a)
        step(); irq_in[0] = 32'h11;
        step(); irq_in[0] = 32'h22;
        step(); irq_in[0] = 32'h33;
        step();
        #2;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("mid_rst_irq_%0d", i), irq_out[i], 32'd0);
            check($sformatf("mid_rst_count_%0d", i), cnt[i], 32'd0);
            check($sformatf("mid_rst_ovf_%0d", i), {31'd0, ovf[i]}, 32'd0);
            check($sformatf("mid_rst_dup_%0d", i), {31'd0, dup[i]}, 32'd0);
        end
        for (int i = 0; i < 3; i++) begin
            irq_in[i] = 32'd0;
            sb[i].delete();
        end
        step();
        step();
        rst_n = 1'b1;
        repeat (40) step();
        @(negedge clk);
        check("post_rst_count_a", cnt[0], 32'd0);
        check("post_rst_irq_a", irq_out[0], 32'd0);
        check("post_rst_count_b", cnt[1], 32'd0);
        check("post_rst_count_c", cnt[2], 32'd0);

        // Nonzero i_irq in the first cycle after release is a capture
        step();
        rst_n = 1'b0;
        irq_in[0] = 32'h55;
        step();
        rst_n = 1'b1;
        sb[0].push_back(32'h55);
        @(negedge clk); check("rel_c0", irq_out[0], 32'd0);
        step(); @(negedge clk); check("rel_c1", irq_out[0], 32'd0);
        step(); @(negedge clk); check("rel_c2", irq_out[0], 32'h55);
        check("rel_count", cnt[0], 32'd1);
        repeat (5) step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
